// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd/lcm datapath: state encoding, widths and step counts.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } lcm_state_e;

    localparam int GCD_W       = 8;
    localparam int LCM_STEPS   = 8;
    localparam int LCM_LATENCY = 17;

endpackage

// File: rtl/div_step_8.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step_8
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic [W-1:0] rem_in,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] trial;

    // The remainder is always below the divisor, so both outcomes fit back into W bits.
    always_comb begin
        trial   = {rem_in, dividend_bit};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
    end

endmodule

// File: rtl/lcm_from_gcd_8.sv
// Sequential LCM = (a / gcd) * b using a restoring divider followed by a shift-add multiplier.
module lcm_from_gcd_8
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   gcd,
    output logic [2*WIDTH-1:0] lcm,
    output logic               out_valid,
    output logic               err
);

    localparam int CW = $clog2(LCM_STEPS);

    lcm_state_e         state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   gcd_q, gcd_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] lcm_q, lcm_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic               last_step;

    div_step_8 #(.W(WIDTH)) u_div_step (
        .rem_in       (rem_q),
        .dividend_bit (dvd_q[WIDTH-1]),
        .divisor      (gcd_q),
        .rem_out      (step_rem),
        .q_bit        (step_qbit)
    );

    assign last_step = (cnt_q == CW'(LCM_STEPS - 1));

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        mcand_d = mcand_q;
        gcd_d   = gcd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        lcm_d   = lcm_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvd_d   = a;
                    mcand_d = {{WIDTH{1'b0}}, b};
                    gcd_d   = gcd;
                    rem_d   = '0;
                    quo_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (a == '0 || b == '0) begin
                        state_d = ST_DONE;
                        lcm_d   = '0;
                        err_d   = 1'b0;
                    end else if (gcd == '0) begin
                        state_d = ST_DONE;
                        lcm_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                dvd_d = dvd_q << 1;
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    cnt_d = '0;
                    acc_d = '0;
                    // A nonzero final remainder means the supplied gcd does not divide a.
                    if (step_rem != '0) begin
                        state_d = ST_DONE;
                        lcm_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (quo_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                quo_d   = quo_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    lcm_d   = acc_d;
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dvd_q       <= '0;
            mcand_q     <= '0;
            gcd_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            lcm_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            mcand_q     <= mcand_d;
            gcd_q       <= gcd_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            lcm_q       <= lcm_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign lcm       = lcm_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_lcm_from_gcd_8.sv
// Directed and randomized checks of lcm_from_gcd_8 against an arithmetic reference model.
`timescale 1ns/100ps
module tb_lcm_from_gcd_8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [7:0]  gcd_in;
    logic [15:0] lcm;
    logic        out_valid;
    logic        err;

    int checks;
    int failures;

    lcm_from_gcd_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .gcd       (gcd_in),
        .lcm       (lcm),
        .out_valid (out_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lcm/err and the number of edges after acceptance until out_valid is seen.
    function automatic void model(input int a, input int b, input int g,
                                  output int exp_lcm, output int exp_err, output int exp_lat);
        if (a == 0 || b == 0) begin
            exp_lcm = 0; exp_err = 0; exp_lat = 0;
        end else if (g == 0) begin
            exp_lcm = 0; exp_err = 1; exp_lat = 0;
        end else if (a % g != 0) begin
            exp_lcm = 0; exp_err = 1; exp_lat = 8;
        end else begin
            exp_lcm = (a / g) * b; exp_err = 0; exp_lat = 16;
        end
    endfunction

    function automatic int true_gcd(input int x, input int y);
        int p = x;
        int q = y;
        int t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issues one request from a post-edge sample point, optionally pulsing a second
    // in_valid at accept+pulse_at, and checks latency, result and handshake.
    task automatic applyStimulus(input string tag, input int a, input int b, input int g, input int pulse_at);
        int exp_lcm, exp_err, exp_lat;
        int k;
        logic busy_bad;
        model(a, b, g, exp_lcm, exp_err, exp_lat);
        checkOutput({tag, "_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_in     = 8'(a);
        b_in     = 8'(b);
        gcd_in   = 8'(g);
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_bad = 1'b0;
        k = 0;
        forever begin
            if (pulse_at > 0 && k == pulse_at - 1) begin
                in_valid = 1'b1; a_in = 8'd4; b_in = 8'd6; gcd_in = 8'd2;
            end
            if (pulse_at > 0 && k == pulse_at) in_valid = 1'b0;
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            if (out_valid === 1'b1 || k >= 40) break;
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        checkOutput({tag, "_latency"}, 32'(k), 32'(exp_lat));
        checkOutput({tag, "_lcm"}, 32'(lcm), 32'(exp_lcm));
        checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
        checkOutput({tag, "_ready_low_busy"}, 32'(busy_bad), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_lcm_hold"}, 32'(lcm), 32'(exp_lcm));
    endtask

    initial begin
        int ra, rb, rg, mode;
        logic seen_valid;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        gcd_in   = '0;

        #12;
        checkOutput("reset_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_lcm", 32'(lcm), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus("basic", 12, 18, 6, 0);
        applyStimulus("max", 255, 254, 1, 0);
        applyStimulus("same", 255, 255, 255, 0);
        applyStimulus("zero_a", 0, 7, 7, 0);
        applyStimulus("gcd_zero", 5, 3, 0, 0);
        applyStimulus("nondiv", 9, 6, 4, 0);

        // Second in_valid mid-operation must leave no trace.
        applyStimulus("ignore", 12, 18, 6, 5);
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        checkOutput("ignore_no_extra", 32'(seen_valid), 32'd0);
        checkOutput("ignore_lcm_kept", 32'(lcm), 32'd36);

        // Abort a request with reset ten edges after acceptance.
        in_valid = 1'b1; a_in = 8'd12; b_in = 8'd18; gcd_in = 8'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #0.5;
        checkOutput("abort_lcm", 32'(lcm), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_ready", 32'(in_ready), 32'd1);
        #0.5;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        checkOutput("abort_no_valid", 32'(seen_valid), 32'd0);
        applyStimulus("after_abort", 4, 6, 2, 0);

        // Randomized requests, mostly with the correct gcd.
        for (int n = 0; n < 24; n++) begin
            ra   = int'($urandom_range(1, 255));
            rb   = int'($urandom_range(1, 255));
            mode = int'($urandom_range(0, 9));
            if (mode < 6) rg = true_gcd(ra, rb);
            else if (mode == 6) rg = 0;
            else if (mode == 7) begin
                rg = true_gcd(ra, rb);
                ra = 0;
            end else rg = int'($urandom_range(1, 255));
            applyStimulus($sformatf("rand%0d", n), ra, rb, rg, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
